// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer.
// Angle scale: 2^(W-2) = pi/2, so a 32-bit angle wraps at +/-pi.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRECORR = 2'd1,
    ST_ITER    = 2'd2,
    ST_DONE    = 2'd3
  } cordic_state_e;

  localparam logic [31:0] ANGLE_PI_HALF_32 = 32'h4000_0000;
  localparam logic [31:0] ANGLE_PI_32      = 32'h8000_0000;

  // Aggregate micro-rotation gain, Q2.30 (1.6467602581)
  localparam logic [31:0] CORDIC_GAIN = 32'h6964_8524;

  // round(atan(2^-i) * 2^31 / pi) for a 32-bit angle word
  localparam logic [31:0] ATAN_TABLE_32 [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Rescales the 32-bit table to a narrower angle word with rounding.
  function automatic logic [31:0] atan_entry(input logic [4:0] idx, input int unsigned width);
    logic [31:0] raw;
    int unsigned sh;
    raw = ATAN_TABLE_32[idx];
    sh  = 32 - width;
    if (sh == 0) return raw;
    return (raw + (32'd1 << (sh - 1))) >> sh;
  endfunction

endpackage

// File: rtl/cordic_if.sv
// Bundle between the iteration sequencer (controller) and the
// combinational micro-rotation core.
interface cordic_if #(
  parameter int p_WIDTH = 32
);
  localparam int c_SHW = $clog2(p_WIDTH);

  logic signed [p_WIDTH-1:0] xprev, yprev, zprev;
  logic signed [p_WIDTH-1:0] xnext, ynext, znext;
  logic                      dir;
  logic                      mode;
  logic        [p_WIDTH-1:0] angle;
  logic        [c_SHW-1:0]   shift_amnt;

  modport controller (
    output xprev, yprev, zprev, dir, mode, angle, shift_amnt,
    input  xnext, ynext, znext
  );

  modport core (
    input  xprev, yprev, zprev, dir, mode, angle, shift_amnt,
    output xnext, ynext, znext
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: idx -> atan(2^-idx) in the angle
// encoding of a p_WIDTH-bit word.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32
) (
  input  logic [$clog2(p_WIDTH)-1:0] idx,
  output logic [p_WIDTH-1:0]         angle
);

  logic [31:0] entry;

  assign entry = atan_entry(5'(idx), p_WIDTH);
  assign angle = entry[p_WIDTH-1:0];

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: loads one job, loops p_ITER passes through the
// external core, presents the result. CORDIC_QUAD_CORR_EN adds a quadrant pre-correction cycle.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | in_ready=1, waiting for a job
//   ST_PRECORR | quadrant fold into convergence range (macro build only)
//   ST_ITER    | one micro-rotation per cycle, i = 0 .. p_ITER-1
//   ST_DONE    | out_valid=1, result held until out_ready
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [p_WIDTH-1:0] in_x,
  input  logic signed [p_WIDTH-1:0] in_y,
  input  logic signed [p_WIDTH-1:0] in_z,
  input  logic                      in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [p_WIDTH-1:0] out_x,
  output logic signed [p_WIDTH-1:0] out_y,
  output logic signed [p_WIDTH-1:0] out_z,
  cordic_if.controller              core
);

  localparam int                c_IW   = $clog2(p_WIDTH);
  localparam logic [c_IW-1:0]   c_LAST = c_IW'(p_ITER - 1);

  cordic_state_e             state, state_nxt;
  logic signed [p_WIDTH-1:0] x_reg, y_reg, z_reg;
  logic                      mode_reg;
  logic [c_IW-1:0]           i_reg;
  logic [p_WIDTH-1:0]        angle_rom;

`ifdef CORDIC_QUAD_CORR_EN
  localparam logic signed [p_WIDTH-1:0] c_PI_HALF = p_WIDTH'(ANGLE_PI_HALF_32 >> (32 - p_WIDTH));
  localparam logic signed [p_WIDTH-1:0] c_PI      = p_WIDTH'(ANGLE_PI_32 >> (32 - p_WIDTH));

  logic signed [p_WIDTH-1:0] x_pc, y_pc, z_pc;

  // Fold the start vector so the remaining angle lies within +/-pi/2.
  always_comb begin
    x_pc = x_reg;
    y_pc = y_reg;
    z_pc = z_reg;
    if (mode_reg) begin
      if (x_reg[p_WIDTH-1]) begin
        x_pc = -x_reg;
        y_pc = -y_reg;
        z_pc = z_reg + c_PI;
      end
    end else if (z_reg > c_PI_HALF) begin
      x_pc = -y_reg;
      y_pc = x_reg;
      z_pc = z_reg - c_PI_HALF;
    end else if (z_reg < -c_PI_HALF) begin
      x_pc = y_reg;
      y_pc = -x_reg;
      z_pc = z_reg + c_PI_HALF;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef CORDIC_QUAD_CORR_EN
          state_nxt = ST_PRECORR;
`else
          state_nxt = ST_ITER;
`endif
        end
      end
      ST_PRECORR: state_nxt = ST_ITER;
      ST_ITER:    if (i_reg == c_LAST) state_nxt = ST_DONE;
      ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
      mode_reg <= 1'b0;
      i_reg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg    <= in_x;
            y_reg    <= in_y;
            z_reg    <= in_z;
            mode_reg <= in_mode;
            i_reg    <= '0;
          end
        end
`ifdef CORDIC_QUAD_CORR_EN
        ST_PRECORR: begin
          x_reg <= x_pc;
          y_reg <= y_pc;
          z_reg <= z_pc;
        end
`endif
        ST_ITER: begin
          x_reg <= core.xnext;
          y_reg <= core.ynext;
          z_reg <= core.znext;
          i_reg <= i_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  cordic_atan_rom #(
    .p_WIDTH (p_WIDTH)
  ) u_atan_rom (
    .idx   (i_reg),
    .angle (angle_rom)
  );

  // Rotation drives z toward 0, vectoring drives y toward 0.
  assign core.dir        = mode_reg ? y_reg[p_WIDTH-1] : ~z_reg[p_WIDTH-1];
  assign core.xprev      = x_reg;
  assign core.yprev      = y_reg;
  assign core.zprev      = z_reg;
  assign core.mode       = mode_reg;
  assign core.angle      = angle_rom;
  assign core.shift_amnt = i_reg;

  assign out_x = x_reg;
  assign out_y = y_reg;
  assign out_z = z_reg;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: supplies the combinational core, runs directed
// jobs and compares every meaningful cycle against a whole-job CORDIC model.
module tb_cordic_iter_ctrl;

  localparam int  W   = 32;
  localparam int  N   = 24;
  localparam int  TOL = 256;
  localparam real PI  = 3.14159265358979323846;
`ifdef CORDIC_QUAD_CORR_EN
  localparam int  LAT = N + 1;
`else
  localparam int  LAT = N;
`endif

  typedef struct {
    int x;
    int y;
    int z;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_mode = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic                in_ready, out_valid;
  logic signed [W-1:0] out_x, out_y, out_z;

  int checks = 0;
  int errors = 0;

  cordic_if #(.p_WIDTH(W)) core_if ();

  cordic_iter_ctrl #(
    .p_WIDTH (W),
    .p_ITER  (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .core      (core_if)
  );

  always #5 clk = ~clk;

  // Combinational micro-rotation core attached to the controller.
  always_comb begin
    if (core_if.dir) begin
      core_if.xnext = core_if.xprev - (core_if.yprev >>> core_if.shift_amnt);
      core_if.ynext = core_if.yprev + (core_if.xprev >>> core_if.shift_amnt);
      core_if.znext = core_if.zprev - core_if.angle;
    end else begin
      core_if.xnext = core_if.xprev + (core_if.yprev >>> core_if.shift_amnt);
      core_if.ynext = core_if.yprev - (core_if.xprev >>> core_if.shift_amnt);
      core_if.znext = core_if.zprev + core_if.angle;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Whole-job reference: optional quadrant fold, then N micro-rotations.
  function automatic vec_t model(input int x0, input int y0, input int z0, input bit m);
    vec_t r;
    int   x, y, z, nx, ny, a;
    real  t;
    bit   d;
    x = x0; y = y0; z = z0;
`ifdef CORDIC_QUAD_CORR_EN
    if (m) begin
      if (x < 0) begin x = -x; y = -y; z = z + 32'sh8000_0000; end
    end else if (z > 1073741824) begin
      nx = -y; y = x; x = nx; z = z - 1073741824;
    end else if (z < -1073741824) begin
      nx = y; y = -x; x = nx; z = z + 1073741824;
    end
`endif
    t = 1.0;
    for (int i = 0; i < N; i++) begin
      a = $rtoi($atan(t) * 2147483648.0 / PI + 0.5);
      d = m ? (y < 0) : (z >= 0);
      if (d) begin nx = x - (y >>> i); ny = y + (x >>> i); z = z - a; end
      else   begin nx = x + (y >>> i); ny = y - (x >>> i); z = z + a; end
      x = nx; y = ny;
      t = t / 2.0;
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  // Transaction-level expectation: job busy for LAT edges, then result held.
  int   m_busy = 0;
  bit   m_valid = 1'b0;
  vec_t m_res = '{0, 0, 0};
  bit   chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_valid = 1'b0;
      m_res   = '{0, 0, 0};
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_valid = 1'b1;
    end else if (in_valid) begin
      m_res  = model(in_x, in_y, in_z, in_mode);
      m_busy = LAT;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", in_ready, (!m_valid && m_busy == 0), 0);
      chk("out_valid", out_valid, m_valid, 0);
      if (m_valid) begin
        chk("out_x", out_x, m_res.x, 0);
        chk("out_y", out_y, m_res.y, 0);
        chk("out_z", out_z, m_res.z, 0);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_job(input int x, input int y, input int z, input bit m, input int hold,
                         output int rx, output int ry, output int rz, output int lat);
    int n;
    in_x = x; in_y = y; in_z = z; in_mode = m; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept_wait", in_ready, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 300);
    chk("done_wait", out_valid, 1, 0);
    rx = out_x; ry = out_y; rz = out_z;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   rx, ry, rz, lat, n;
    vec_t pin;

    pin = model(32'h2000_0000, 0, 0, 1'b0);
    chk("model_pin_rot_x", pin.x, 32'h34B2_4285, TOL);
    pin = model(32'h2000_0000, 32'h2000_0000, 0, 1'b1);
    chk("model_pin_vec_z", pin.z, 32'h2000_0000, TOL);

    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_out_x", out_x, 0, 0);
    chk("rst_out_y", out_y, 0, 0);
    chk("rst_out_z", out_z, 0, 0);
    chk("rst_dir", core_if.dir, 1, 0);
    chk("rst_mode", core_if.mode, 0, 0);
    chk("rst_shift", core_if.shift_amnt, 0, 0);
    chk("rst_angle", core_if.angle, 32'h2000_0000, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    run_job(32'h2000_0000, 0, 0, 1'b0, 0, rx, ry, rz, lat);
    chk("rot0_latency", lat, LAT + 1, 0);
    chk("rot0_x", rx, 32'h34B2_4285, TOL);
    chk("rot0_y", ry, 0, TOL);
    chk("rot0_z", rz, 0, TOL);

    run_job(32'h2000_0000, 0, 32'h4000_0000, 1'b0, 2, rx, ry, rz, lat);
    chk("rot90_x", rx, 0, TOL);
    chk("rot90_y", ry, 32'h34B2_4285, TOL);
    chk("rot90_z", rz, 0, TOL);

    run_job(32'h2000_0000, 32'h2000_0000, 0, 1'b1, 0, rx, ry, rz, lat);
    chk("vec45_x", rx, 32'h4A86_1C00, TOL);
    chk("vec45_y", ry, 0, TOL);
    chk("vec45_z", rz, 32'h2000_0000, TOL);

    run_job(32'h2000_0000, 0, 32'h6000_0000, 1'b0, 0, rx, ry, rz, lat);
`ifdef CORDIC_QUAD_CORR_EN
    chk("rot135_x", rx, -longint'(32'h2543_0E00), TOL);
    chk("rot135_y", ry, 32'h2543_0E00, TOL);
    chk("rot135_z", rz, 0, TOL);
`else
    chk("rot135_z_nonconv", (rz > 32'sh0100_0000 || rz < -32'sh0100_0000), 1, 0);
`endif

    run_job(32'h1000_0000, 32'h0800_0000, -32'sh6000_0000, 1'b0, 1, rx, ry, rz, lat);
    run_job(-32'sh1000_0000, 32'h0800_0000, 0, 1'b1, 0, rx, ry, rz, lat);

    // Backpressure: result held 5 cycles with a second job pending.
    in_x = 32'h2000_0000; in_y = 0; in_z = 32'h1000_0000; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 32'h1800_0000; in_y = 32'h0400_0000; in_z = 0; in_mode = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 300);
    chk("bp_done_wait", out_valid, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1, 0);
      chk("bp_hold_ready", in_ready, 0, 0);
      chk("bp_hold_x", out_x, m_res.x, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_hs_ready", in_ready, 1, 0);
    chk("bp_after_hs_valid", out_valid, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accepted", in_ready, 0, 0);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("bp_second_done", out_valid, 1, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during iteration 10 drops the job.
    in_x = 32'h2000_0000; in_y = 0; in_z = 32'h0800_0000; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - N + 10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1, 0);
    chk("midrst_out_valid", out_valid, 0, 0);
    chk("midrst_out_x", out_x, 0, 0);
    chk("midrst_out_y", out_y, 0, 0);
    chk("midrst_out_z", out_z, 0, 0);
    chk("midrst_dir", core_if.dir, 1, 0);
    chk("midrst_mode", core_if.mode, 0, 0);
    chk("midrst_shift", core_if.shift_amnt, 0, 0);
    chk("midrst_angle", core_if.angle, 32'h2000_0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(32'h2000_0000, 0, 0, 1'b0, 0, rx, ry, rz, lat);
    chk("post_rst_latency", lat, LAT + 1, 0);
    chk("post_rst_x", rx, 32'h34B2_4285, TOL);
    chk("post_rst_y", ry, 0, TOL);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
